// File: rtl/xbus_arbiter.sv
`default_nettype none
// xbus_arbiter -- round-robin NUM_MASTERS-to-one X-bus arbiter with per-cycle grant lock, rev 1.0
// Optional bus-timeout watchdog is built when XBUS_ARB_TIMEOUT_EN is defined.
module xbus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] mdat_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] madr_i,
  input  logic [NUM_MASTERS-1:0]        mwe_i,
  input  logic [NUM_MASTERS-1:0]        mcyc_i,
  input  logic [NUM_MASTERS-1:0]        mstb_i,
  input  logic [NUM_MASTERS*2-1:0]      msiz_i,
  input  logic [NUM_MASTERS-1:0]        msigned_i,
  output logic [NUM_MASTERS-1:0]        mack_o,
  output logic [NUM_MASTERS-1:0]        merr_o,
  output logic [DATA_W-1:0]             mdat_o,
  output logic [NUM_MASTERS-1:0]        gnt_o,
  output logic [DATA_W-1:0]             xdat_o,
  output logic [ADDR_W-1:0]             xadr_o,
  output logic                          xwe_o,
  output logic                          xcyc_o,
  output logic                          xstb_o,
  output logic [1:0]                    xsiz_o,
  output logic                          xsigned_o,
  input  logic                          xack_i,
  input  logic [DATA_W-1:0]             xdat_i
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] gnt;
  logic [NUM_MASTERS-1:0] gnt_next;
  logic [IDX_W-1:0]       last;
  logic [IDX_W-1:0]       last_next;
  logic                   arb_en;

  // Re-arbitrate when idle or when the owner has released its cycle.
  always_comb begin : arbitrate
    logic found;
    int   cand;
    found     = 1'b0;
    cand      = 0;
    gnt_next  = gnt;
    last_next = last;
    arb_en    = (gnt == '0) || ((gnt & mcyc_i) == '0);
    if (arb_en) begin
      gnt_next = '0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
        cand = (int'(last) + i) % NUM_MASTERS;
        if (!found && mcyc_i[cand]) begin
          found           = 1'b1;
          gnt_next        = '0;
          gnt_next[cand]  = 1'b1;
          last_next       = IDX_W'(cand);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      gnt  <= '0;
      last <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      gnt  <= gnt_next;
      last <= last_next;
    end
  end

  // One-hot select of the owner's request slice; everything is zero while idle.
  always_comb begin : bus_mux
    xdat_o    = '0;
    xadr_o    = '0;
    xwe_o     = 1'b0;
    xcyc_o    = 1'b0;
    xstb_o    = 1'b0;
    xsiz_o    = 2'b00;
    xsigned_o = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (gnt[k]) begin
        xdat_o    = mdat_i[k*DATA_W +: DATA_W];
        xadr_o    = madr_i[k*ADDR_W +: ADDR_W];
        xwe_o     = mwe_i[k];
        xcyc_o    = mcyc_i[k];
        xstb_o    = mstb_i[k];
        xsiz_o    = msiz_i[k*2 +: 2];
        xsigned_o = msigned_i[k];
      end
    end
  end

`ifdef XBUS_ARB_TIMEOUT_EN
  localparam int CNT_W = 16;

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));

  // A hit reports for exactly one cycle, then the count restarts.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      tmo_cnt <= '0;
    end else if ((gnt_next != gnt) || tmo_hit || !xstb_o || xack_i) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  assign merr_o = (tmo_hit && !xack_i) ? gnt : '0;
`else
  assign merr_o = '0;
`endif

  assign mack_o = {NUM_MASTERS{xack_i}} & gnt & ~merr_o;
  assign mdat_o = xdat_i;
  assign gnt_o  = gnt;

endmodule
`default_nettype wire

// File: tb/tb_xbus_arbiter.sv
`default_nettype none
// tb_xbus_arbiter -- vector table and scoreboard bench for xbus_arbiter with four masters.
module tb_xbus_arbiter;

  localparam int N   = 4;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int TMO = 4;

  localparam logic [N-1:0] WE_TAB = 4'b1010;
  localparam logic [N-1:0] SG_TAB = 4'b1100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic [N*DW-1:0] mdat;
  logic [N*AW-1:0] madr;
  logic [N-1:0]    mwe, mcyc, mstb, msigned;
  logic [N*2-1:0]  msiz;
  logic [N-1:0]    mack, merr, gnt;
  logic [DW-1:0]   mdat_out, xdat_out, xdat_in;
  logic [AW-1:0]   xadr;
  logic            xwe, xcyc, xstb, xsigned, xack;
  logic [1:0]      xsiz;

  logic [AW-1:0] adr_tab [N];
  logic [DW-1:0] dat_tab [N];

  typedef struct {
    logic [N-1:0] mcyc;
    logic [N-1:0] mstb;
    logic         xack;
    logic [N-1:0] gnt;
    logic [N-1:0] mack;
  } vec_t;

  typedef struct {
    logic [N-1:0]  gnt;
    logic [N-1:0]  mack;
    logic [N-1:0]  merr;
    logic [N-1:0]  mcyc;
    logic [N-1:0]  mstb;
    logic [DW-1:0] mdat;
  } exp_t;

  vec_t tab[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  xbus_arbiter #(
    .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .reset_i(reset_n),
    .mdat_i(mdat), .madr_i(madr), .mwe_i(mwe), .mcyc_i(mcyc), .mstb_i(mstb),
    .msiz_i(msiz), .msigned_i(msigned),
    .mack_o(mack), .merr_o(merr), .mdat_o(mdat_out), .gnt_o(gnt),
    .xdat_o(xdat_out), .xadr_o(xadr), .xwe_o(xwe), .xcyc_o(xcyc), .xstb_o(xstb),
    .xsiz_o(xsiz), .xsigned_o(xsigned),
    .xack_i(xack), .xdat_i(xdat_in)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_outputs(input string nm, input exp_t e);
    int   o;
    logic any;
    o   = 0;
    any = 1'b0;
    for (int k = 0; k < N; k++) if (e.gnt[k]) begin o = k; any = 1'b1; end
    chk({nm, " gnt"},     gnt,      e.gnt);
    chk({nm, " mack"},    mack,     e.mack);
    chk({nm, " merr"},    merr,     e.merr);
    chk({nm, " mdat"},    mdat_out, e.mdat);
    chk({nm, " xcyc"},    xcyc,     any ? e.mcyc[o] : 1'b0);
    chk({nm, " xstb"},    xstb,     any ? e.mstb[o] : 1'b0);
    chk({nm, " xadr"},    xadr,     any ? adr_tab[o] : '0);
    chk({nm, " xdat"},    xdat_out, any ? dat_tab[o] : '0);
    chk({nm, " xwe"},     xwe,      any ? WE_TAB[o] : 1'b0);
    chk({nm, " xsiz"},    xsiz,     any ? 2'(o) : 2'b00);
    chk({nm, " xsigned"}, xsigned,  any ? SG_TAB[o] : 1'b0);
  endtask

  // Drive one cycle of requests, queue the expectation, compare after the edge.
  task automatic step(input string nm, input logic [N-1:0] c, input logic [N-1:0] s,
                      input logic a, input logic [N-1:0] eg, input logic [N-1:0] em,
                      input logic [N-1:0] ee);
    exp_t          e;
    logic [DW-1:0] d;
    mcyc   = c;
    mstb   = s;
    xack   = a;
    e.gnt  = eg;
    e.mack = em;
    e.merr = ee;
    e.mcyc = c;
    e.mstb = s;
    e.mdat = '0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    d       = {$urandom(), $urandom()};
    xdat_in = d;
    e       = sb.pop_front();
    e.mdat  = d;
    #1;
    check_outputs(nm, e);
  endtask

  task automatic add(input logic [N-1:0] c, input logic [N-1:0] s, input logic a,
                     input logic [N-1:0] g, input logic [N-1:0] m);
    vec_t v;
    v.mcyc = c; v.mstb = s; v.xack = a; v.gnt = g; v.mack = m;
    tab.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    adr_tab = '{64'h0F00, 64'h1000, 64'h2000, 64'h3000};
    dat_tab = '{64'hA0A0_0000_0000_00A0, 64'hB1B1_0000_0000_00B1,
                64'hC2C2_0000_0000_00C2, 64'hD3D3_0000_0000_00D3};
    madr    = {adr_tab[3], adr_tab[2], adr_tab[1], adr_tab[0]};
    mdat    = {dat_tab[3], dat_tab[2], dat_tab[1], dat_tab[0]};
    mwe     = WE_TAB;
    msigned = SG_TAB;
    msiz    = {2'd3, 2'd2, 2'd1, 2'd0};
    xdat_in = 64'h0000_0000_DEAD_BEEF;

    // round robin 0,1,2,3,0 with release one cycle after each ack
    add(4'b1111, 4'b0000, 1'b0, 4'b0001, 4'b0000);
    add(4'b1111, 4'b0001, 1'b1, 4'b0001, 4'b0001);
    add(4'b1110, 4'b0000, 1'b0, 4'b0010, 4'b0000);
    add(4'b1111, 4'b0010, 1'b1, 4'b0010, 4'b0010);
    add(4'b1101, 4'b0000, 1'b0, 4'b0100, 4'b0000);
    add(4'b1111, 4'b0100, 1'b1, 4'b0100, 4'b0100);
    add(4'b1011, 4'b0000, 1'b0, 4'b1000, 4'b0000);
    add(4'b1111, 4'b1000, 1'b1, 4'b1000, 4'b1000);
    add(4'b0111, 4'b0000, 1'b0, 4'b0001, 4'b0000);
    // lock: master 0 holds across three strobes while master 1 waits
    add(4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0001);
    add(4'b0011, 4'b0001, 1'b0, 4'b0001, 4'b0000);
    add(4'b0011, 4'b0001, 1'b1, 4'b0001, 4'b0001);
    add(4'b0011, 4'b0000, 1'b0, 4'b0001, 4'b0000);
    add(4'b0011, 4'b0001, 1'b1, 4'b0001, 4'b0001);
    add(4'b0011, 4'b0001, 1'b1, 4'b0001, 4'b0001);
    add(4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0000);
    add(4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0010);
    // idle, strobe without cycle, rotation resumes after last owner
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0100, 1'b1, 4'b0000, 4'b0000);
    add(4'b0101, 4'b0000, 1'b0, 4'b0100, 4'b0000);
    add(4'b0100, 4'b0100, 1'b1, 4'b0100, 4'b0100);
    // sole requester is the previous owner: search wraps back to it
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000);
    add(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000);
    add(4'b1001, 4'b0000, 1'b0, 4'b1000, 4'b0000);
    add(4'b1001, 4'b1000, 1'b1, 4'b1000, 4'b1000);
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000);

    // reset held with every master requesting
    reset_n = 1'b0;
    mcyc    = 4'b1111;
    mstb    = 4'b1111;
    xack    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    e = '{gnt: '0, mack: '0, merr: '0, mcyc: mcyc, mstb: mstb, mdat: xdat_in};
    check_outputs("reset", e);
    reset_n = 1'b1;

    for (int i = 0; i < tab.size(); i++)
      step($sformatf("vec%0d", i), tab[i].mcyc, tab[i].mstb, tab[i].xack,
           tab[i].gnt, tab[i].mack, 4'b0000);

    // asynchronous reset between edges during a transfer
    step("ar_grant", 4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0000, 4'b0000);
    #2;
    reset_n = 1'b0;
    #1;
    e = '{gnt: '0, mack: '0, merr: '0, mcyc: mcyc, mstb: mstb, mdat: xdat_in};
    check_outputs("ar_mid", e);
    mcyc = 4'b1111;
    @(posedge clk);
    #1;
    chk("ar_held gnt", gnt, 4'b0000);
    reset_n = 1'b1;
    step("ar_release", 4'b1111, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000);

`ifdef XBUS_ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++)
      step($sformatf("tmo_stall%0d", i), 4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000);
    step("tmo_hit", 4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0001);
    step("tmo_clear", 4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++)
      step($sformatf("tmo_restall%0d", i), 4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    chk("tmo_rehit merr", merr, 4'b0001);
    chk("tmo_rehit mack", mack, 4'b0000);
    xack = 1'b1;
    #1;
    chk("tmo_ackwins merr", merr, 4'b0000);
    chk("tmo_ackwins mack", mack, 4'b0001);
`else
    for (int i = 0; i < 8; i++)
      step($sformatf("stall%0d", i), 4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000);
`endif
    step("final_idle", 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xbus_arbiter.md
# xbus_arbiter

Parametrised N-master bus arbiter. It merges NUM_MASTERS CPU-side ports (I-port, D-port, DMA, debug) onto the single X-bus that feeds address decode, ROM and peripherals. It generalises the fixed two-port I/D arbiter with three additions:
- a configurable master count,
- fair round-robin grant, held for the whole bus cycle,
- an optional bus-timeout watchdog that terminates unacknowledged transfers with an error strobe.

## Interface
Parameters:
- NUM_MASTERS, 2, number of requesting ports (2..8); master index 0 = I-port by convention.
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- TIMEOUT_CYCLES, 255, stall limit for the watchdog (1..65535); ignored when the watchdog is compiled out.

Ports:
- clk_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- mdat_i  in  NUM_MASTERS*DATA_W  write data; master k occupies slice k.
- madr_i  in  NUM_MASTERS*ADDR_W  address, sliced per master.
- mwe_i  in  NUM_MASTERS  write enable per master.
- mcyc_i  in  NUM_MASTERS  bus-cycle request/lock per master.
- mstb_i  in  NUM_MASTERS  transfer strobe per master.
- msiz_i  in  NUM_MASTERS*2  transfer size per master (0=byte … 3=dword).
- msigned_i  in  NUM_MASTERS  sign-extend read per master.
- mack_o  out  NUM_MASTERS  acknowledge, asserted only to the owner.
- merr_o  out  NUM_MASTERS  timeout error, asserted only to the owner.
- mdat_o  out  DATA_W  read data, broadcast to all masters (valid with mack_o).
- gnt_o  out  NUM_MASTERS  one-hot current owner; all-zero when idle.
- xdat_o, xadr_o, xwe_o, xcyc_o, xstb_o, xsiz_o, xsigned_o  out  DATA_W, ADDR_W, 1, 1, 1, 2, 1  X-bus request signals.
- xack_i  in  1  X-bus acknowledge.
- xdat_i  in  DATA_W  X-bus read data.

## Operation
- Registered state:
  - gnt (one-hot owner, or zero).
  - last (index of the most recent owner).
  - timeout counter, only when the watchdog is compiled in.
- Arbitration is evaluated on every rising edge where either condition holds:
  - gnt is zero, or
  - the owner's mcyc_i is low.
- At an arbitration edge:
  - The winner is the first k with mcyc_i[k]=1, searching last+1, last+2, … modulo NUM_MASTERS.
  - gnt ← one-hot(winner) and last ← winner.
  - If no mcyc_i is set, gnt ← 0 and last is unchanged.
- Ownership is held while the owner's mcyc_i stays high. Other requests wait, whatever their index.
- X-bus request outputs are a combinational mux of the owner's slice:
  - xcyc_o = owner mcyc_i; xstb_o = owner mstb_i.
  - When gnt=0, every x* output is 0.
- mack_o[k] = xack_i & gnt[k] & ~merr_o[k]. mdat_o = xdat_i, passed through with no register.
- A request needs mcyc_i high at an edge to be granted. This gives one cycle of grant latency from mcyc_i rising.
- Handover: if the owner drops mcyc_i and another master is requesting at the same edge, the new owner is granted on that edge, with no dead cycle.
- A master raising mstb_i without mcyc_i is ignored.

## Timing
- Reset (reset_i low, asynchronous):
  - gnt=0 and last=NUM_MASTERS-1, so master 0 wins first.
  - Counter=0.
  - All outputs 0: gnt_o, mack_o, merr_o, x*; mdat_o follows xdat_i.
- Reset asserted mid-transfer drops ownership immediately. The X-bus strobe falls asynchronously.
- Request to grant: 1 edge. Grant to xstb_o: 0 cycles (combinational). xack_i to mack_o: 0 cycles.
- Simultaneous requests at reset: 0, 1, 2, … in rotation.
- Owner releasing while the only other requester is the owner itself re-grants the same master (the search wraps back to it).

## Configuration
- XBUS_ARB_TIMEOUT_EN defined:
  - The counter increments each cycle that xstb_o=1 and xack_i=0.
  - It clears on xack_i, on xstb_o=0, and on any gnt change.
  - While the counter equals TIMEOUT_CYCLES, merr_o[owner]=1 for that cycle, then the counter clears. The master must drop stb or cyc.
  - If xack_i=1 in that same cycle, the ack wins and merr_o stays 0.
- XBUS_ARB_TIMEOUT_EN undefined: no counter is built, merr_o is tied 0, and a stalled slave hangs the owner indefinitely.

## Test plan
- Reset: reset_i=0 with all mcyc_i=1 -> gnt_o=0 and x* =0. After release, gnt_o=01 (N=2) one edge later.
- Round-robin: N=4, all mcyc_i held high, each master drops mcyc_i one cycle after its ack -> grant order 0,1,2,3,0 with no idle cycle.
- Lock: master 0 keeps mcyc_i high across 3 strobes while master 1 requests -> gnt_o stays 0001 until master 0 releases, then becomes 0010 on that edge.
- Mux/ack: master 1 granted, madr_i slice 1=0x1000, xack_i pulsed with xdat_i=0xDEADBEEF -> xadr_o=0x1000, mack_o=10, mdat_o=0xDEADBEEF, mack_o[0]=0.
- Timeout (macro on, TIMEOUT_CYCLES=4): xack_i held 0 -> merr_o[owner]=1 on the 5th stalled cycle, mack_o=0. Repeat with xack_i=1 exactly on that cycle -> ack delivered, no error.
- Async reset mid-cycle: reset_i pulled low between edges during a transfer -> xstb_o and gnt_o fall before the next edge.
